// File: rtl/mcb_arb_pkg.sv
// Shared constants and types for the DDR2 command-port arbiter.
package mcb_arb_pkg;

    // Default field widths for the controller command port
    localparam int ADDR_W = 30;
    localparam int BL_W   = 6;

    // Controller command encodings
    localparam logic [2:0] INSTR_WR = 3'b000;
    localparam logic [2:0] INSTR_RD = 3'b001;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mcb_cmd_arbiter_rr_pick.sv
// Combinational round-robin picker over requesters 1..NREQ-1.
// Search starts at ptr and wraps from NREQ-1 back to 1.
module rr_pick #(
    parameter int NREQ  = 3,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:1]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:1]  pick,
    output logic             valid
);

    // Two passes: first from ptr upward, then the wrapped part below ptr
    always_comb begin
        pick  = '0;
        valid = 1'b0;
        for (int i = 1; i < NREQ; i++) begin
            if (!valid && req[i] && (i >= int'(ptr))) begin
                pick[i] = 1'b1;
                valid   = 1'b1;
            end
        end
        for (int i = 1; i < NREQ; i++) begin
            if (!valid && req[i] && (i < int'(ptr))) begin
                pick[i] = 1'b1;
                valid   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mcb_cmd_arbiter.sv
// Arbitrates the single DDR2 controller command port between line-transfer
// requesters. Requester 0 (display fetch) has fixed priority; the rest share
// round-robin, and a requester left waiting STARVE_MAX cycles overrides 0.
module mcb_cmd_arbiter #(
    parameter int NREQ       = 3,
    parameter int ADDR_W     = mcb_arb_pkg::ADDR_W,
    parameter int BL_W       = mcb_arb_pkg::BL_W,
    parameter int STARVE_MAX = 64
) (
    input  logic                   mem_clk,
    input  logic                   rst_n,
    input  logic                   calib_done,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*BL_W-1:0]   req_bl,
    output logic [NREQ-1:0]        gnt,
    output logic                   busy,
    output logic                   cmd_en,
    output logic [2:0]             cmd_instr,
    output logic [BL_W-1:0]        cmd_bl,
    output logic [ADDR_W-1:0]      cmd_byte_addr,
    input  logic                   cmd_full
);
    import mcb_arb_pkg::*;

    localparam int PTR_W = $clog2(NREQ);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0]  STARVE_SAT = CNT_W'(STARVE_MAX);
    localparam logic [ADDR_W-1:0] ADDR_MASK  = ~ADDR_W'(3);

    arb_state_t       state;
    logic [NREQ-1:0]  win_q;
    logic [NREQ-1:0]  win_nxt;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic [CNT_W-1:0] starve [1:NREQ-1];
    logic [NREQ-1:1]  rr_oh;
    logic             rr_valid;
    logic             starve_hit;
    logic             sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [BL_W-1:0]  sel_bl;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req   (req[NREQ-1:1]),
        .ptr   (ptr),
        .pick  (rr_oh),
        .valid (rr_valid)
    );

    // The strobe follows cmd_full directly so a stalled command issues on the first free cycle
    assign cmd_en = (state == ISSUE) && !cmd_full;
    assign gnt    = cmd_en ? win_q : '0;
    assign busy   = (state != IDLE);

    // Winner: starved lower requester first, then requester 0, then round-robin
    always_comb begin
        win_nxt    = '0;
        starve_hit = 1'b0;
        for (int i = 1; i < NREQ; i++) begin
            if (!starve_hit && req[i] && (starve[i] == STARVE_SAT)) begin
                win_nxt[i] = 1'b1;
                starve_hit = 1'b1;
            end
        end
        if (!starve_hit) begin
            if (req[0]) begin
                win_nxt[0] = 1'b1;
            end else if (rr_valid) begin
                win_nxt[NREQ-1:1] = rr_oh;
            end
        end
    end

    // One-hot mux of the winning requester's command fields
    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_bl   = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_we   = sel_we | (req_we[i] & win_nxt[i]);
            sel_addr = sel_addr | (req_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{win_nxt[i]}});
            sel_bl   = sel_bl | (req_bl[i*BL_W +: BL_W] & {BL_W{win_nxt[i]}});
        end
    end

    // Pointer moves past a granted lower requester; a grant to 0 leaves it alone
    always_comb begin
        ptr_nxt = ptr;
        for (int i = 1; i < NREQ; i++) begin
            if (win_q[i]) begin
                ptr_nxt = (i == NREQ - 1) ? PTR_W'(1) : PTR_W'(i + 1);
            end
        end
    end

    // Command FSM: latch winner in IDLE, hold in ISSUE until accepted, one GAP cycle
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            win_q         <= '0;
            ptr           <= PTR_W'(1);
            cmd_instr     <= '0;
            cmd_bl        <= '0;
            cmd_byte_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (calib_done && (|req)) begin
                        win_q         <= win_nxt;
                        cmd_instr     <= sel_we ? INSTR_WR : INSTR_RD;
                        cmd_bl        <= sel_bl;
                        cmd_byte_addr <= sel_addr & ADDR_MASK;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!cmd_full) begin
                        ptr   <= ptr_nxt;
                        state <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Starvation counters; waiting before calibration does not count as being starved
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREQ; i++) begin
                starve[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREQ; i++) begin
                if (gnt[i] || !req[i]) begin
                    starve[i] <= '0;
                end else if (calib_done && !(busy && win_q[i]) && (starve[i] != STARVE_SAT)) begin
                    starve[i] <= starve[i] + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mcb_cmd_arbiter.sv
// Directed bench for mcb_cmd_arbiter: vector table plus multi-cycle sequences.
module tb_mcb_cmd_arbiter;

    localparam int NREQ   = 3;
    localparam int ADDR_W = 30;
    localparam int BL_W   = 6;

    logic                   mem_clk = 1'b0;
    logic                   rst_n;
    logic                   calib_done;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*BL_W-1:0]   req_bl;
    logic [NREQ-1:0]        gnt;
    logic                   busy;
    logic                   cmd_en;
    logic [2:0]             cmd_instr;
    logic [BL_W-1:0]        cmd_bl;
    logic [ADDR_W-1:0]      cmd_byte_addr;
    logic                   cmd_full;

    int vec_count  = 0;
    int miss_count = 0;

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [89:0] addr;
        logic [17:0] bl;
        logic [2:0]  exp_gnt;
        logic [2:0]  exp_instr;
        logic [29:0] exp_addr;
        logic [5:0]  exp_bl;
    } vec_t;

    vec_t vecs [8];

    mcb_cmd_arbiter #(
        .NREQ       (NREQ),
        .ADDR_W     (ADDR_W),
        .BL_W       (BL_W),
        .STARVE_MAX (64)
    ) dut (
        .mem_clk       (mem_clk),
        .rst_n         (rst_n),
        .calib_done    (calib_done),
        .req           (req),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_bl        (req_bl),
        .gnt           (gnt),
        .busy          (busy),
        .cmd_en        (cmd_en),
        .cmd_instr     (cmd_instr),
        .cmd_bl        (cmd_bl),
        .cmd_byte_addr (cmd_byte_addr),
        .cmd_full      (cmd_full)
    );

    // Free-running memory clock
    always #5 mem_clk = ~mem_clk;

    // Hard stop in case a sequence never returns
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge mem_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        req      = v.req;
        req_we   = v.we;
        req_addr = v.addr;
        req_bl   = v.bl;
    endtask

    task automatic doReset();
        @(posedge mem_clk);
        #1;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // Main directed sequence
    initial begin
        logic [2:0] grants [4];
        int         gcyc   [4];
        int         ng;
        int         n0;
        int         seen2;
        logic [2:0] after2;
        int         stall_en;
        int         extra;

        rst_n      = 1'b1;
        calib_done = 1'b0;
        req        = '0;
        req_we     = '0;
        req_addr   = '0;
        req_bl     = '0;
        cmd_full   = 1'b0;

        vecs[0] = '{3'b010, 3'b010, {30'h3FFF_FFFF, 30'h0000_1235, 30'h0ABC_DEF3}, {6'd0, 6'd31, 6'd5},
                    3'b010, 3'b000, 30'h0000_1234, 6'd31};
        vecs[1] = '{3'b100, 3'b000, {30'h3FFF_FFFF, 30'h0000_1235, 30'h0ABC_DEF3}, {6'd0, 6'd31, 6'd5},
                    3'b100, 3'b001, 30'h3FFF_FFFC, 6'd0};
        vecs[2] = '{3'b111, 3'b001, {30'h3FFF_FFFF, 30'h0000_1235, 30'h0ABC_DEF3}, {6'd0, 6'd31, 6'd5},
                    3'b001, 3'b000, 30'h0ABC_DEF0, 6'd5};
        vecs[3] = '{3'b110, 3'b100, {30'h1234_5677, 30'h0000_0002, 30'h2000_0001}, {6'd17, 6'd63, 6'd1},
                    3'b010, 3'b001, 30'h0000_0000, 6'd63};
        vecs[4] = '{3'b110, 3'b100, {30'h1234_5677, 30'h0000_0002, 30'h2000_0001}, {6'd17, 6'd63, 6'd1},
                    3'b100, 3'b000, 30'h1234_5674, 6'd17};
        vecs[5] = '{3'b011, 3'b100, {30'h1234_5677, 30'h0000_0002, 30'h2000_0001}, {6'd17, 6'd63, 6'd1},
                    3'b001, 3'b001, 30'h2000_0000, 6'd1};
        vecs[6] = '{3'b100, 3'b000, {30'h1234_5677, 30'h0000_0002, 30'h2000_0001}, {6'd17, 6'd63, 6'd1},
                    3'b100, 3'b001, 30'h1234_5674, 6'd17};
        vecs[7] = '{3'b010, 3'b111, {30'h1234_5677, 30'h0000_0002, 30'h2000_0001}, {6'd17, 6'd63, 6'd1},
                    3'b010, 3'b000, 30'h0000_0000, 6'd63};

        // Reset state
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_cmd_en", 32'(cmd_en), 32'd0);
        checkOutput("reset_gnt", 32'(gnt), 32'd0);
        checkOutput("reset_fields", 32'(cmd_instr) | 32'(cmd_bl) | 32'(cmd_byte_addr), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;

        // No grants before calibration, then requester 0 first
        req = 3'b111;
        extra = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            @(negedge mem_clk);
            if (cmd_en || (|gnt)) extra++;
        end
        checkOutput("uncal_no_cmd", 32'(extra), 32'd0);
        tick();
        calib_done = 1'b1;
        @(negedge mem_clk);
        checkOutput("cal_wait_cmd_en", 32'(cmd_en), 32'd0);
        tick();
        @(negedge mem_clk);
        checkOutput("cal_cmd_en", 32'(cmd_en), 32'd1);
        checkOutput("cal_gnt", 32'(gnt), 32'h1);
        req = '0;

        // Table-driven single-command vectors
        doReset();
        for (int i = 0; i < 8; i++) begin
            req = '0;
            repeat (4) tick();
            applyStimulus(vecs[i]);
            tick();
            @(negedge mem_clk);
            checkOutput($sformatf("v%0d_cmd_en", i), 32'(cmd_en), 32'd1);
            checkOutput($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vecs[i].exp_gnt));
            checkOutput($sformatf("v%0d_instr", i), 32'(cmd_instr), 32'(vecs[i].exp_instr));
            checkOutput($sformatf("v%0d_addr", i), 32'(cmd_byte_addr), 32'(vecs[i].exp_addr));
            checkOutput($sformatf("v%0d_bl", i), 32'(cmd_bl), 32'(vecs[i].exp_bl));
            tick();
            req = '0;
            @(negedge mem_clk);
            checkOutput($sformatf("v%0d_pulse_end", i), 32'(cmd_en) | 32'(gnt), 32'd0);
        end

        // Round-robin alternation between 1 and 2 with 3-cycle spacing
        req = '0;
        doReset();
        req = 3'b110;
        ng  = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            @(negedge mem_clk);
            if ((|gnt) && ng < 4) begin
                grants[ng] = gnt;
                gcyc[ng]   = c;
                ng++;
            end
        end
        checkOutput("rr_count", 32'(ng), 32'd4);
        if (ng == 4) begin
            checkOutput("rr_g0", 32'(grants[0]), 32'h2);
            checkOutput("rr_g1", 32'(grants[1]), 32'h4);
            checkOutput("rr_g2", 32'(grants[2]), 32'h2);
            checkOutput("rr_g3", 32'(grants[3]), 32'h4);
            checkOutput("rr_first_latency", 32'(gcyc[0]), 32'd1);
            for (int k = 1; k < 4; k++) begin
                checkOutput($sformatf("rr_spacing%0d", k), 32'(gcyc[k] - gcyc[k-1]), 32'd3);
            end
        end

        // Requester 0 hogging; requester 2 wins once its counter saturates
        req = '0;
        repeat (4) tick();
        req    = 3'b101;
        n0     = 0;
        seen2  = 0;
        after2 = '0;
        for (int c = 0; c < 300 && after2 == 3'b000; c++) begin
            tick();
            @(negedge mem_clk);
            if (|gnt) begin
                if (seen2 != 0) after2 = gnt;
                else if (gnt == 3'b100) seen2 = 1;
                else if (gnt == 3'b001) n0++;
            end
        end
        checkOutput("starve_r0_grants", 32'(n0), 32'd22);
        checkOutput("starve_r2_granted", 32'(seen2), 32'd1);
        checkOutput("starve_r0_resumes", 32'(after2), 32'h1);

        // cmd_full stall: req and calib_done drop while stalled, command still issues once
        req = '0;
        repeat (4) tick();
        req      = 3'b010;
        req_we   = 3'b000;
        cmd_full = 1'b1;
        tick();
        stall_en = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge mem_clk);
            if (cmd_en || (|gnt) || !busy) stall_en++;
            tick();
            if (k == 0) begin
                req        = '0;
                calib_done = 1'b0;
            end
        end
        checkOutput("stall_no_cmd_en", 32'(stall_en), 32'd0);
        cmd_full = 1'b0;
        @(negedge mem_clk);
        checkOutput("stall_release_cmd_en", 32'(cmd_en), 32'd1);
        checkOutput("stall_release_gnt", 32'(gnt), 32'h2);
        extra = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            @(negedge mem_clk);
            if (cmd_en || (|gnt)) extra++;
        end
        checkOutput("stall_single_pulse", 32'(extra), 32'd0);
        calib_done = 1'b1;

        // Reset asserted mid-ISSUE discards the pending command
        tick();
        req      = 3'b100;
        req_we   = 3'b000;
        cmd_full = 1'b1;
        tick();
        @(negedge mem_clk);
        checkOutput("pre_rst_busy", 32'(busy), 32'd1);
        checkOutput("pre_rst_instr", 32'(cmd_instr), 32'd1);
        #2;
        rst_n    = 1'b0;
        req      = '0;
        cmd_full = 1'b0;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_cmd_en_gnt", 32'(cmd_en) | 32'(gnt), 32'd0);
        checkOutput("midrst_instr", 32'(cmd_instr), 32'd0);
        checkOutput("midrst_bl", 32'(cmd_bl), 32'd0);
        checkOutput("midrst_addr", 32'(cmd_byte_addr), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge mem_clk);
            if (cmd_en || (|gnt) || busy) extra++;
        end
        checkOutput("post_rst_no_stale", 32'(extra), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/mcb_cmd_arbiter.md
Name: mcb_cmd_arbiter

Overview:
- Shares the single DDR2 memory-controller command port, in the `mem_clk` domain, between line-transfer requesters.
- Requester 0 is the display line fetch, which is deadline-critical. The others are the background-subtractor write-back and the blob-analyzer reads.
- Requester 0 gets fixed priority. Lower requesters are served round-robin, with starvation escalation so none is blocked indefinitely.
- Command issue only; data FIFOs stay owned by each requester.

Parameters:
- NREQ, 3, number of requesters (index 0 = priority class).
- ADDR_W, 30, byte address width.
- BL_W, 6, burst length field width (value = words-1).
- STARVE_MAX, 64, wait cycles after which a lower requester overrides requester 0.

Ports:
- mem_clk  in  1  memory-controller clock; single clock.
- rst_n  in  1  asynchronous active-low reset.
- calib_done  in  1  controller calibration complete; no grants while low.
- req  in  NREQ  per-requester command request, level.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*ADDR_W  packed byte addresses, requester i at [i*ADDR_W +: ADDR_W].
- req_bl  in  NREQ*BL_W  packed burst lengths.
- gnt  out  NREQ  one-hot, one-cycle pulse when that requester's command is accepted.
- busy  out  1  high in any state other than IDLE.
- cmd_en  out  1  command strobe to controller.
- cmd_instr  out  3  3'b000 write, 3'b001 read.
- cmd_bl  out  BL_W  burst length.
- cmd_byte_addr  out  ADDR_W  byte address, bits [1:0] forced to 0.
- cmd_full  in  1  controller command FIFO full.

Behaviour:

Reset (rst_n low, immediate, also mid-operation):
- gnt=0, cmd_en=0, busy=0, cmd_instr=0, cmd_bl=0, cmd_byte_addr=0.
- State=IDLE, round-robin pointer=1, all starvation counters=0.
- Any command latched but not yet issued is discarded.

FSM has three states: IDLE, ISSUE, GAP.
- IDLE: if calib_done and |req, pick the winner, latch its we/addr/bl into the command registers, then go to ISSUE.
- ISSUE:
  - cmd_en = ~cmd_full (combinational from state).
  - gnt[winner] = cmd_en.
  - Stay in ISSUE while cmd_full is high; leave for GAP on the cycle cmd_en=1.
- GAP: one idle cycle so the requester can update or drop req; then return to IDLE.
- Minimum spacing is 3 cycles per command. Latency from req rise (in IDLE, cmd_full low) to cmd_en/gnt is 1 cycle.

Winner selection:
1. Lowest-index requester i>0 with req[i] and starve[i]==STARVE_MAX.
2. Otherwise req[0].
3. Otherwise round-robin among i>0: first requester with req set, starting at the pointer and wrapping from NREQ-1 to 1.
- On grant of i>0, pointer = i+1, wrapping to 1. A grant to requester 0 leaves the pointer unchanged.

Starvation counters (i>0):
- Increment each cycle while req[i] is high and i is not the current latched winner.
- Saturate at STARVE_MAX.
- Clear on gnt[i]. Also clear when req[i] is low.

Rules and boundary conditions:
- Requests are non-retractable once latched: the command issues even if req drops during ISSUE.
- Requesters must hold we/addr/bl stable while req is high.
- calib_done falling during ISSUE does not abort the pending command; it blocks only new arbitration in IDLE.
- cmd_full high for N cycles in ISSUE gives exactly one cmd_en, on the first cycle it is low. No command is ever dropped or duplicated.
- Simultaneous req on all inputs with no starvation: requester 0 wins.
- req_bl passes through unchanged; 0 means 1 word.

Decomposition:
- Package mcb_arb_pkg holds:
  - constants INSTR_WR=3'b000 and INSTR_RD=3'b001;
  - FSM state encoding (IDLE, ISSUE, GAP);
  - default widths ADDR_W and BL_W.
- One sub-module, rr_pick: combinational round-robin picker. Inputs are request vector and pointer; outputs are one-hot pick and valid. Used for step 3 of winner selection.

Test Plan:
- Reset release, calib_done=0, req=3'b111 → no cmd_en or gnt for 100 cycles. Set calib_done=1 → cmd_en one cycle later with gnt=3'b001.
- Only req[1], we=1, addr=0x0000_1235, bl=31 → cmd_instr=000, cmd_byte_addr=0x0000_1234, cmd_bl=31, gnt=3'b010, one pulse.
- req[1] and req[2] held continuously, req[0]=0 → grants alternate 1, 2, 1, 2, spaced exactly 3 cycles apart.
- req[0] held continuously together with req[2] → requester 0 granted repeatedly. Requester 2 is granted after its starvation counter reaches 64, then requester 0 resumes.
- cmd_full high for 10 cycles while in ISSUE → cmd_en=0 throughout, then exactly one cmd_en+gnt pulse when cmd_full falls.
- rst_n pulled low during ISSUE with cmd_full=1 → outputs zero immediately. After release, no stale command is issued.
